// File: rtl/oven_led_ctrl.sv
// Oven status-LED controller: picks a display mode from the oven condition
// inputs and turns it into a light pattern, with all timing from a tick
// prescaler.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  M_OFF   | oven idle, LED dark
//  M_SOLID | heating element active, LED steadily lit
//  M_SLOW  | temperature reached, slow blink (SLOW_HALF ticks per half)
//  M_FAST  | door open while enabled, fast blink (FAST_HALF ticks per half)
//  M_DONE  | cooking finished, DONE_BLINKS fast on-pulses then dark
//  M_FAULT | fault present, LED toggles on every tick
module oven_led_ctrl #(
  parameter int TICK_DIV    = 1000,
  parameter int SLOW_HALF   = 50,
  parameter int FAST_HALF   = 10,
  parameter int DONE_BLINKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oven_on,
  input  logic       heating,
  input  logic       temp_ok,
  input  logic       door_open,
  input  logic       fault,
  input  logic       cook_done,
  output logic       led,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_SOLID = 3'd1,
    M_SLOW  = 3'd2,
    M_FAST  = 3'd3,
    M_DONE  = 3'd4,
    M_FAULT = 3'd5
  } mode_t;

  localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(MAX_HALF + 1);
  localparam int BW = $clog2(DONE_BLINKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] SLOW_LAST  = PW'(SLOW_HALF - 1);
  localparam logic [PW-1:0] FAST_LAST  = PW'(FAST_HALF - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(DONE_BLINKS - 1);

  mode_t          mode_q, mode_d;
  logic           led_q, led_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [BW-1:0]  blink_q, blink_d;
  logic           done_pending_q, done_pending_d;

  logic           abort;
  logic           start;
  logic           restart;
  logic           blinking;
  logic [PW-1:0]  phase_last;

  // Next-state: mode arbitration, prescaler, phase timing and done burst.
  always_comb begin
    abort          = fault | (oven_on & door_open);
    // A pulse arriving while a burst is playing is ignored; one arriving in
    // the same cycle as a higher-priority condition is discarded.
    start          = cook_done & ~abort & ~done_pending_q;
    done_pending_d = ~abort & (done_pending_q | start);

    if (fault)                     mode_d = M_FAULT;
    else if (oven_on & door_open)  mode_d = M_FAST;
    else if (done_pending_d)       mode_d = M_DONE;
    else if (oven_on & heating)    mode_d = M_SOLID;
    else if (oven_on & temp_ok)    mode_d = M_SLOW;
    else                           mode_d = M_OFF;

    // A fresh burst right after one ended keeps mode DONE but must still
    // start from a clean first phase.
    restart = (mode_d != mode_q) | start;

    case (mode_q)
      M_SLOW:  phase_last = SLOW_LAST;
      M_FAULT: phase_last = '0;
      default: phase_last = FAST_LAST;
    endcase

    blinking = (mode_q == M_SLOW) | (mode_q == M_FAST) | (mode_q == M_FAULT) |
               ((mode_q == M_DONE) & done_pending_q);

    led_d   = led_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    blink_d = blink_q;

    if (restart) begin
      tick_d  = '0;
      phase_d = '0;
      blink_d = '0;
      led_d   = (mode_d != M_OFF);
    end else begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
      if ((tick_q == TICK_LAST) && blinking) begin
        if (phase_q == phase_last) begin
          phase_d = '0;
          led_d   = ~led_q;
          if ((mode_q == M_DONE) && led_q) begin
            if (blink_q == BLINK_LAST) begin
              done_pending_d = 1'b0;
              led_d          = 1'b0;
            end else begin
              blink_d = blink_q + BW'(1);
            end
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q         <= M_OFF;
      led_q          <= 1'b0;
      tick_q         <= '0;
      phase_q        <= '0;
      blink_q        <= '0;
      done_pending_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      led_q          <= led_d;
      tick_q         <= tick_d;
      phase_q        <= phase_d;
      blink_q        <= blink_d;
      done_pending_q <= done_pending_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_oven_led_ctrl.sv
// Bench for oven_led_ctrl: directed scenarios followed by randomized input
// sequences, compared every cycle against a cycle-count based reference model.
module tb_oven_led_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int SLOW_HALF   = 5;
  localparam int FAST_HALF   = 2;
  localparam int DONE_BLINKS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       oven_on, heating, temp_ok, door_open, fault, cook_done;
  logic       led;
  logic [2:0] mode;

  int checks   = 0;
  int failures = 0;

  // reference model state: mode, LED, cycles since mode entry, burst flag
  int m_mode = 0;
  int m_led  = 0;
  int m_el   = 0;
  int m_pend = 0;

  oven_led_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .SLOW_HALF  (SLOW_HALF),
    .FAST_HALF  (FAST_HALF),
    .DONE_BLINKS(DONE_BLINKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .oven_on  (oven_on),
    .heating  (heating),
    .temp_ok  (temp_ok),
    .door_open(door_open),
    .fault    (fault),
    .cook_done(cook_done),
    .led      (led),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  function automatic int half_cycles(int md);
    case (md)
      2:       return SLOW_HALF * TICK_DIV;
      5:       return TICK_DIV;
      default: return FAST_HALF * TICK_DIV;
    endcase
  endfunction

  // Reference: LED level follows from how many whole half-periods have
  // elapsed since the mode was entered.
  task automatic model_step();
    int abort, start, new_pend, target;
    if (!reset) begin
      m_mode = 0; m_led = 0; m_el = 0; m_pend = 0;
      return;
    end
    abort    = (fault || (oven_on && door_open)) ? 1 : 0;
    start    = (cook_done && !abort && !m_pend) ? 1 : 0;
    new_pend = (!abort && (m_pend || start)) ? 1 : 0;
    if (fault)                      target = 5;
    else if (oven_on && door_open)  target = 3;
    else if (new_pend)              target = 4;
    else if (oven_on && heating)    target = 1;
    else if (oven_on && temp_ok)    target = 2;
    else                            target = 0;
    if (target != m_mode || start) begin
      m_mode = target;
      m_el   = 0;
      m_led  = (target != 0) ? 1 : 0;
      m_pend = new_pend;
    end else begin
      m_el   = m_el + 1;
      m_pend = new_pend;
      case (m_mode)
        0: m_led = 0;
        1: m_led = 1;
        4: begin
          if (m_pend) begin
            if (m_el == (2 * DONE_BLINKS - 1) * half_cycles(4)) begin
              m_pend = 0;
              m_led  = 0;
            end else begin
              m_led = ((m_el / half_cycles(4)) % 2 == 0) ? 1 : 0;
            end
          end else begin
            m_led = 0;
          end
        end
        default: m_led = ((m_el / half_cycles(m_mode)) % 2 == 0) ? 1 : 0;
      endcase
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_led"},  {7'd0, led},  8'(m_led));
    chk({tag, "_mode"}, {5'd0, mode}, 8'(m_mode));
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic set_in(logic on, logic ht, logic tok, logic dr, logic flt);
    oven_on = on; heating = ht; temp_ok = tok; door_open = dr; fault = flt;
  endtask

  task automatic pulse_done(string tag);
    cook_done = 1'b1;
    cycle(tag);
    cook_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1, 1, 0, 0, 0);
    cook_done = 1'b0;
    #2;

    // reset held with oven_on/heating asserted
    for (int i = 0; i < 3; i++) begin
      cycle("rst_hold");
      chk("rst_led_zero", {7'd0, led}, 8'd0);
      chk("rst_mode_off", {5'd0, mode}, 8'd0);
    end
    reset = 1'b1;
    cycle("rst_release");
    chk("release_mode_solid", {5'd0, mode}, 8'd1);
    chk("release_led_on", {7'd0, led}, 8'd1);
    run("solid", 10);

    // slow blink: 20 on / 20 off
    set_in(1, 0, 1, 0, 0);
    run("slow", 90);

    // door open then closed
    set_in(1, 1, 0, 1, 0);
    run("fast", 40);
    door_open = 1'b0;
    cycle("door_drop");
    chk("door_drop_mode", {5'd0, mode}, 8'd1);
    chk("door_drop_led", {7'd0, led}, 8'd1);
    run("solid2", 5);

    // done burst with a second pulse mid-burst
    set_in(0, 0, 0, 0, 0);
    run("idle", 3);
    pulse_done("done_start");
    chk("done_mode", {5'd0, mode}, 8'd4);
    run("done_a", 20);
    pulse_done("done_again");
    run("done_b", 40);
    chk("done_end_mode", {5'd0, mode}, 8'd0);
    chk("done_end_led", {7'd0, led}, 8'd0);

    // fault in the same cycle as cook_done
    fault = 1'b1;
    pulse_done("fault_done");
    chk("fault_mode", {5'd0, mode}, 8'd5);
    run("fault", 16);
    fault = 1'b0;
    run("fault_drop", 50);
    chk("no_burst_mode", {5'd0, mode}, 8'd0);

    // reset in the middle of a burst
    pulse_done("burst2");
    run("burst2", 3);
    reset = 1'b0;
    cycle("mid_reset");
    chk("mid_reset_led", {7'd0, led}, 8'd0);
    chk("mid_reset_mode", {5'd0, mode}, 8'd0);
    reset = 1'b1;
    run("post_reset", 50);

    // burst while oven disabled then oven enabled and heating after
    pulse_done("burst3");
    set_in(1, 1, 0, 0, 0);
    run("burst3_on", 60);

    // randomized segments
    for (int seg = 0; seg < 150; seg++) begin
      int hold;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) reset = 1'b0;
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 2) == 0) begin
        pulse_done("rnd_pulse");
        reset = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
        if (i == 1) reset = 1'b1;
        if ($urandom_range(0, 24) == 0) cook_done = 1'b1;
        cycle("rnd");
        cook_done = 1'b0;
      end
      reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
